// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter feeding the reservation-station
// operand-capture stage. Each functional unit owns one holding buffer. Up to
// BUS_COUNT buffered results are granted per cycle in round-robin order and
// broadcast on registered result buses for exactly one cycle.
//
// Optional build macro: CDB_ARBITER_FLUSH_EN adds a 1-bit flush input that
// discards all buffered results, clears the buses and resets the pointer.
//
// Ports:
//   clock         clock
//   reset         synchronous, active-high reset
//   flush         (CDB_ARBITER_FLUSH_EN only) discard buffered results
//   unit_valid    unit i presents a result
//   unit_source   station tag of unit i, flat [i*STATION_INDEX_SIZE +: STATION_INDEX_SIZE]
//   unit_value    result value of unit i, flat [i*SIZE +: SIZE]
//   unit_ready    unit i result accepted this cycle if valid (combinational)
//   bus_asserted  bus k carries a result this cycle (registered)
//   bus_source    tag on bus k, flat [k*STATION_INDEX_SIZE +: STATION_INDEX_SIZE]
//   bus_value     value on bus k, flat [k*SIZE +: SIZE]
module cdb_arbiter #(
    parameter int SIZE               = 32,
    parameter int STATION_INDEX_SIZE = 1,
    parameter int BUS_COUNT          = 1,
    parameter int UNIT_COUNT         = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
`ifdef CDB_ARBITER_FLUSH_EN
    input  logic                                     flush,
`endif
    input  logic [UNIT_COUNT-1:0]                    unit_valid,
    input  logic [STATION_INDEX_SIZE*UNIT_COUNT-1:0] unit_source,
    input  logic [SIZE*UNIT_COUNT-1:0]               unit_value,
    output logic [UNIT_COUNT-1:0]                    unit_ready,
    output logic [BUS_COUNT-1:0]                     bus_asserted,
    output logic [STATION_INDEX_SIZE*BUS_COUNT-1:0]  bus_source,
    output logic [SIZE*BUS_COUNT-1:0]                bus_value
);

    localparam int PTR_W = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1;

    logic [UNIT_COUNT-1:0]         held;
    logic [STATION_INDEX_SIZE-1:0] held_source [UNIT_COUNT];
    logic [SIZE-1:0]               held_value  [UNIT_COUNT];
    logic [PTR_W-1:0]              pointer;
    logic [PTR_W-1:0]              pointer_d;

    logic [UNIT_COUNT-1:0]                   granted;
    int                                      unit_slot [UNIT_COUNT];
    int                                      grant_count;
    int                                      last_unit;
    logic [BUS_COUNT-1:0]                    bus_asserted_d;
    logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source_d;
    logic [SIZE*BUS_COUNT-1:0]               bus_value_d;
    logic                                    flush_active;

`ifdef CDB_ARBITER_FLUSH_EN
    assign flush_active = flush;
`else
    assign flush_active = 1'b0;
`endif

    // Round-robin scan from the pointer; the n-th held unit found gets slot n.
    always_comb begin
        granted     = '0;
        grant_count = 0;
        last_unit   = 0;
        for (int i = 0; i < UNIT_COUNT; i++) begin
            unit_slot[i] = 0;
        end
        for (int j = 0; j < UNIT_COUNT; j++) begin
            for (int i = 0; i < UNIT_COUNT; i++) begin
                if (((int'(pointer) + j) % UNIT_COUNT) == i && held[i] &&
                    grant_count < BUS_COUNT) begin
                    granted[i]   = 1'b1;
                    unit_slot[i] = grant_count;
                    grant_count  = grant_count + 1;
                    last_unit    = i;
                end
            end
        end
    end

    // A granted buffer frees up this cycle, so its unit may refill with no bubble.
    always_comb begin
        unit_ready = (~held | granted) & {UNIT_COUNT{~flush_active}};
    end

    always_comb begin
        bus_asserted_d = '0;
        bus_source_d   = '0;
        bus_value_d    = '0;
        for (int n = 0; n < BUS_COUNT; n++) begin
            for (int i = 0; i < UNIT_COUNT; i++) begin
                if (granted[i] && unit_slot[i] == n) begin
                    bus_asserted_d[n]                                         = 1'b1;
                    bus_source_d[n*STATION_INDEX_SIZE +: STATION_INDEX_SIZE] = held_source[i];
                    bus_value_d[n*SIZE +: SIZE]                               = held_value[i];
                end
            end
        end
    end

    always_comb begin
        pointer_d = pointer;
        if (grant_count > 0) begin
            if (last_unit + 1 >= UNIT_COUNT) begin
                pointer_d = '0;
            end else begin
                pointer_d = PTR_W'(last_unit + 1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush_active) begin
            held         <= '0;
            pointer      <= '0;
            bus_asserted <= '0;
            bus_source   <= '0;
            bus_value    <= '0;
            for (int i = 0; i < UNIT_COUNT; i++) begin
                held_source[i] <= '0;
                held_value[i]  <= '0;
            end
        end else begin
            pointer      <= pointer_d;
            bus_asserted <= bus_asserted_d;
            bus_source   <= bus_source_d;
            bus_value    <= bus_value_d;
            for (int i = 0; i < UNIT_COUNT; i++) begin
                if (unit_valid[i] && unit_ready[i]) begin
                    held[i]        <= 1'b1;
                    held_source[i] <= unit_source[i*STATION_INDEX_SIZE +: STATION_INDEX_SIZE];
                    held_value[i]  <= unit_value[i*SIZE +: SIZE];
                end else if (granted[i]) begin
                    held[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter. Two instances
// share the unit inputs: dut1 with one result bus, dut2 with two.
module tb_cdb_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic [3:0]   unit_valid = '0;
    logic [7:0]   unit_source = '0;
    logic [127:0] unit_value = '0;

    logic [3:0]   ready1;
    logic [0:0]   bus1_asserted;
    logic [1:0]   bus1_source;
    logic [31:0]  bus1_value;
    logic [3:0]   ready2;
    logic [1:0]   bus2_asserted;
    logic [3:0]   bus2_source;
    logic [63:0]  bus2_value;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cdb_arbiter #(
        .SIZE(32), .STATION_INDEX_SIZE(2), .BUS_COUNT(1), .UNIT_COUNT(4)
    ) dut1 (
        .clock(clock),
        .reset(reset),
`ifdef CDB_ARBITER_FLUSH_EN
        .flush(flush),
`endif
        .unit_valid(unit_valid),
        .unit_source(unit_source),
        .unit_value(unit_value),
        .unit_ready(ready1),
        .bus_asserted(bus1_asserted),
        .bus_source(bus1_source),
        .bus_value(bus1_value)
    );

    cdb_arbiter #(
        .SIZE(32), .STATION_INDEX_SIZE(2), .BUS_COUNT(2), .UNIT_COUNT(4)
    ) dut2 (
        .clock(clock),
        .reset(reset),
`ifdef CDB_ARBITER_FLUSH_EN
        .flush(flush),
`endif
        .unit_valid(unit_valid),
        .unit_source(unit_source),
        .unit_value(unit_value),
        .unit_ready(ready2),
        .bus_asserted(bus2_asserted),
        .bus_source(bus2_source),
        .bus_value(bus2_value)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_unit(input int i, input logic [1:0] s, input logic [31:0] v);
        unit_valid[i]          = 1'b1;
        unit_source[i*2 +: 2]  = s;
        unit_value[i*32 +: 32] = v;
    endtask

    task automatic clear_units();
        unit_valid = '0;
    endtask

    task automatic do_reset();
        clear_units();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus1_asserted !== 1'b0 || bus1_source !== 2'd0 || bus1_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus1: got %b/%h/%h expected 0/0/0",
                     bus1_asserted, bus1_source, bus1_value);
        end
        checks++;
        if (ready1 !== 4'b1111 || ready2 !== 4'b1111) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b expected 1111/1111", ready1, ready2);
        end
        checks++;
        if (bus2_asserted !== 2'b00 || bus2_source !== 4'd0 || bus2_value !== 64'd0) begin
            errors++;
            $display("FAIL reset_bus2: got %b/%h/%h expected 0/0/0",
                     bus2_asserted, bus2_source, bus2_value);
        end
    endtask

    task automatic test_single_latency();
        do_reset();
        set_unit(2, 2'd1, 32'hDEADBEEF);
        tick();
        clear_units();
        checks++;
        if (bus1_asserted !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got asserted=%b expected 0", bus1_asserted);
        end
        tick();
        checks++;
        if (bus1_asserted !== 1'b1 || bus1_source !== 2'd1 || bus1_value !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_bus: got %b/%h/%h expected 1/1/deadbeef",
                     bus1_asserted, bus1_source, bus1_value);
        end
        tick();
        checks++;
        if (bus1_asserted !== 1'b0 || bus1_value !== 32'd0) begin
            errors++;
            $display("FAIL single_after: got %b/%h expected 0/0", bus1_asserted, bus1_value);
        end
    endtask

    task automatic test_all_units_one_bus();
        logic [3:0] exp_ready [6];
        exp_ready = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
        do_reset();
        for (int i = 0; i < 4; i++) set_unit(i, 2'(i), 32'(10 + i));
        tick();
        clear_units();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (ready1 !== exp_ready[k]) begin
                errors++;
                $display("FAIL all_ready[%0d]: got %b expected %b", k, ready1, exp_ready[k]);
            end
            checks++;
            if (k >= 1 && k <= 4) begin
                if (bus1_asserted !== 1'b1 || bus1_source !== 2'(k - 1) ||
                    bus1_value !== 32'(9 + k)) begin
                    errors++;
                    $display("FAIL all_bus[%0d]: got %b/%h/%0d expected 1/%0d/%0d",
                             k, bus1_asserted, bus1_source, bus1_value, k - 1, 9 + k);
                end
            end else if (bus1_asserted !== 1'b0) begin
                errors++;
                $display("FAIL all_bus[%0d]: got asserted=%b expected 0", k, bus1_asserted);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_value;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            clear_units();
            if (k < 5) begin
                set_unit(1, 2'd2, 32'(100 + k));
                set_unit(3, 2'd1, 32'(200 + k));
            end
            checks++;
            if (ready2 !== 4'b1111) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1111", k, ready2);
            end
            checks++;
            if (k >= 2 && k <= 6) begin
                exp_value = {32'(200 + k - 2), 32'(100 + k - 2)};
                if (bus2_asserted !== 2'b11 || bus2_source !== 4'b0110 ||
                    bus2_value !== exp_value) begin
                    errors++;
                    $display("FAIL b2b_bus[%0d]: got %b/%b/%h expected 11/0110/%h",
                             k, bus2_asserted, bus2_source, bus2_value, exp_value);
                end
            end else if (bus2_asserted !== 2'b00) begin
                errors++;
                $display("FAIL b2b_bus[%0d]: got asserted=%b expected 00", k, bus2_asserted);
            end
            tick();
        end
        clear_units();
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        set_unit(2, 2'd2, 32'h22);
        tick();
        clear_units();
        set_unit(0, 2'd0, 32'hA0);
        set_unit(3, 2'd3, 32'hA3);
        tick();
        clear_units();
        checks++;
        if (bus1_asserted !== 1'b1 || bus1_value !== 32'h22) begin
            errors++;
            $display("FAIL wrap_first: got %b/%h expected 1/22", bus1_asserted, bus1_value);
        end
        checks++;
        if (ready1 !== 4'b1110) begin
            errors++;
            $display("FAIL wrap_ready: got %b expected 1110", ready1);
        end
        tick();
        checks++;
        if (bus1_asserted !== 1'b1 || bus1_source !== 2'd3 || bus1_value !== 32'hA3) begin
            errors++;
            $display("FAIL wrap_unit3: got %b/%h/%h expected 1/3/a3",
                     bus1_asserted, bus1_source, bus1_value);
        end
        tick();
        checks++;
        if (bus1_asserted !== 1'b1 || bus1_source !== 2'd0 || bus1_value !== 32'hA0) begin
            errors++;
            $display("FAIL wrap_unit0: got %b/%h/%h expected 1/0/a0",
                     bus1_asserted, bus1_source, bus1_value);
        end
        // Pointer should now be 1, so unit 1 wins over unit 0.
        set_unit(0, 2'd0, 32'hB0);
        set_unit(1, 2'd1, 32'hB1);
        tick();
        clear_units();
        tick();
        checks++;
        if (bus1_asserted !== 1'b1 || bus1_value !== 32'hB1) begin
            errors++;
            $display("FAIL wrap_ptr1_first: got %b/%h expected 1/b1", bus1_asserted, bus1_value);
        end
        tick();
        checks++;
        if (bus1_asserted !== 1'b1 || bus1_value !== 32'hB0) begin
            errors++;
            $display("FAIL wrap_ptr1_second: got %b/%h expected 1/b0", bus1_asserted, bus1_value);
        end
        tick();
        checks++;
        if (bus1_asserted !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle: got asserted=%b expected 0", bus1_asserted);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_unit(0, 2'd0, 32'hC0);
        set_unit(1, 2'd1, 32'hC1);
        set_unit(2, 2'd2, 32'hC2);
        tick();
        clear_units();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus1_asserted !== 1'b0 || bus2_asserted !== 2'b00) begin
            errors++;
            $display("FAIL midreset_bus: got %b/%b expected 0/00", bus1_asserted, bus2_asserted);
        end
        checks++;
        if (ready1 !== 4'b1111 || ready2 !== 4'b1111) begin
            errors++;
            $display("FAIL midreset_ready: got %b/%b expected 1111/1111", ready1, ready2);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus1_asserted !== 1'b0 || bus2_asserted !== 2'b00) begin
                errors++;
                $display("FAIL midreset_stale[%0d]: got %b/%b expected 0/00",
                         k, bus1_asserted, bus2_asserted);
            end
        end
    endtask

`ifdef CDB_ARBITER_FLUSH_EN
    task automatic test_flush();
        do_reset();
        set_unit(0, 2'd0, 32'hF0);
        set_unit(1, 2'd1, 32'hF1);
        tick();
        clear_units();
        flush = 1'b1;
        #1;
        checks++;
        if (ready1 !== 4'b0000) begin
            errors++;
            $display("FAIL flush_ready: got %b expected 0000", ready1);
        end
        tick();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus1_asserted !== 1'b0 || bus2_asserted !== 2'b00) begin
                errors++;
                $display("FAIL flush_bus[%0d]: got %b/%b expected 0/00",
                         k, bus1_asserted, bus2_asserted);
            end
            tick();
        end
        set_unit(3, 2'd3, 32'h33);
        tick();
        clear_units();
        checks++;
        if (bus1_asserted !== 1'b0) begin
            errors++;
            $display("FAIL flush_new_early: got asserted=%b expected 0", bus1_asserted);
        end
        tick();
        checks++;
        if (bus1_asserted !== 1'b1 || bus1_source !== 2'd3 || bus1_value !== 32'h33) begin
            errors++;
            $display("FAIL flush_new: got %b/%h/%h expected 1/3/33",
                     bus1_asserted, bus1_source, bus1_value);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_latency();
        test_all_units_one_bus();
        test_back_to_back();
        test_pointer_wrap();
        test_mid_reset();
`ifdef CDB_ARBITER_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
